// File: rtl/cernbe_arbiter.sv
`timescale 1ns/1ps
// cernbe_arbiter
// Two-master round-robin arbiter in front of a single shared, word-addressed
// bus. One transaction is in flight at a time. The FSM walks
// IDLE -> ISSUE -> WAIT -> DONE, and every output comes from a register.
//
// Ports
//   aclk, areset            clock; synchronous active-high reset
//   mN_addr_i / mN_data_i   master N address and write data (N = 0, 1)
//   mN_rd_i / mN_wr_i       master N level requests; rd+wr together is a write
//   mN_data_o               master N read data; changes only on its read completion
//   mN_done_o / mN_err_o    one-cycle completion pulse and error flag valid with it
//   sub_VMEAddr_o           shared-bus address, held until the next grant
//   sub_VMEWrData_o         shared-bus write data, held until the next grant
//   sub_VMERdData_i         shared-bus read data
//   sub_VMERdMem_o          one-cycle read strobe
//   sub_VMEWrMem_o          one-cycle write strobe
//   sub_VMERdDone_i         read completion from the bus
//   sub_VMEWrDone_i         write completion from the bus
//   grant_o                 one-hot current owner, 00 when idle
//
// Build option
//   CERNBE_ARB_TIMEOUT_EN   When defined, a transaction that sits in ISSUE+WAIT
//                           for TIMEOUT cycles with no completion ends with
//                           err=1. A timed-out read returns 0xFFFFFFFF. When
//                           not defined, WAIT has no limit and mN_err_o is
//                           tied low.
module cernbe_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int TIMEOUT    = 255
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [31:0]           m0_data_i,
    input  logic                  m0_rd_i,
    input  logic                  m0_wr_i,
    output logic [31:0]           m0_data_o,
    output logic                  m0_done_o,
    output logic                  m0_err_o,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [31:0]           m1_data_i,
    input  logic                  m1_rd_i,
    input  logic                  m1_wr_i,
    output logic [31:0]           m1_data_o,
    output logic                  m1_done_o,
    output logic                  m1_err_o,
    output logic [ADDR_WIDTH-1:0] sub_VMEAddr_o,
    output logic [31:0]           sub_VMEWrData_o,
    input  logic [31:0]           sub_VMERdData_i,
    output logic                  sub_VMERdMem_o,
    output logic                  sub_VMEWrMem_o,
    input  logic                  sub_VMERdDone_i,
    input  logic                  sub_VMEWrDone_i,
    output logic [1:0]            grant_o
);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
        $error("cernbe_arbiter: TIMEOUT must lie in 1..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        last_grant;   // 1 = master 1 was served last
    logic        owner;        // master being served
    logic        is_wr;        // direction of the transaction in flight
    logic        req0;
    logic        req1;
    logic        pick;
    logic        pick_wr;
    logic        done_ok;
    logic        expire;
    logic [31:0] rd_value;

`ifdef CERNBE_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [15:0] tmo_cnt;

    // Holds 0 in IDLE, so the ISSUE cycle is count 0. Expiry therefore
    // lands on the TIMEOUT-th cycle spent in ISSUE+WAIT.
    always_ff @(posedge aclk) begin
        if (areset) begin
            tmo_cnt <= 16'd0;
        end else if (state == S_ISSUE || state == S_WAIT) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end else begin
            tmo_cnt <= 16'd0;
        end
    end

    assign expire = (tmo_cnt == TMO_LAST);
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        req0       = m0_rd_i | m0_wr_i;
        req1       = m1_rd_i | m1_wr_i;
        // On a tie the master that was not served last wins.
        pick       = (req0 && req1) ? ~last_grant : req1;
        pick_wr    = pick ? m1_wr_i : m0_wr_i;
        // A completion counts only if it matches the direction in flight.
        done_ok    = is_wr ? sub_VMEWrDone_i : sub_VMERdDone_i;
`ifdef CERNBE_ARB_TIMEOUT_EN
        // A completion in the expiry cycle wins over the timeout.
        rd_value   = done_ok ? sub_VMERdData_i : 32'hFFFF_FFFF;
`else
        rd_value   = sub_VMERdData_i;
`endif
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE, S_WAIT: begin
                if (done_ok || expire) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Each output register is loaded on the FSM transition that enters its
    // state. A strobe or done pulse therefore shows up in the cycle the FSM
    // spends in ISSUE or DONE.
    always_ff @(posedge aclk) begin
        if (areset) begin
            last_grant      <= 1'b1;
            owner           <= 1'b0;
            is_wr           <= 1'b0;
            grant_o         <= 2'b00;
            sub_VMERdMem_o  <= 1'b0;
            sub_VMEWrMem_o  <= 1'b0;
            sub_VMEAddr_o   <= '0;
            sub_VMEWrData_o <= 32'd0;
            m0_done_o       <= 1'b0;
            m1_done_o       <= 1'b0;
            m0_data_o       <= 32'd0;
            m1_data_o       <= 32'd0;
        end else begin
            sub_VMERdMem_o <= 1'b0;
            sub_VMEWrMem_o <= 1'b0;
            m0_done_o      <= 1'b0;
            m1_done_o      <= 1'b0;

            if (state == S_IDLE && state_next == S_ISSUE) begin
                owner           <= pick;
                is_wr           <= pick_wr;
                sub_VMEAddr_o   <= pick ? m1_addr_i : m0_addr_i;
                sub_VMEWrData_o <= pick ? m1_data_i : m0_data_i;
                grant_o         <= pick ? 2'b10 : 2'b01;
                sub_VMERdMem_o  <= ~pick_wr;
                sub_VMEWrMem_o  <= pick_wr;
            end

            if (state != S_DONE && state_next == S_DONE) begin
                m0_done_o <= ~owner;
                m1_done_o <= owner;
                if (!is_wr) begin
                    if (owner) begin
                        m1_data_o <= rd_value;
                    end else begin
                        m0_data_o <= rd_value;
                    end
                end
            end

            if (state == S_DONE) begin
                grant_o    <= 2'b00;
                last_grant <= owner;
            end
        end
    end

`ifdef CERNBE_ARB_TIMEOUT_EN
    always_ff @(posedge aclk) begin
        if (areset) begin
            m0_err_o <= 1'b0;
            m1_err_o <= 1'b0;
        end else begin
            m0_err_o <= 1'b0;
            m1_err_o <= 1'b0;
            if (state != S_DONE && state_next == S_DONE) begin
                m0_err_o <= ~owner & ~done_ok;
                m1_err_o <= owner & ~done_ok;
            end
        end
    end
`else
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cernbe_arbiter.sv
`timescale 1ns/1ps
module tb_cernbe_arbiter;

    localparam int AW = 14;
`ifdef CERNBE_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic          aclk = 1'b0;
    logic          areset;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic          m0_rd, m0_wr, m1_rd, m1_wr;
    logic [31:0]   m0_data_o, m1_data_o;
    logic          m0_done_o, m1_done_o, m0_err_o, m1_err_o;
    logic [AW-1:0] sub_addr;
    logic [31:0]   sub_wdata, sub_rdata;
    logic          sub_rd_mem, sub_wr_mem, sub_rd_done, sub_wr_done;
    logic [1:0]    grant_o;

    cernbe_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .aclk           (aclk),
        .areset         (areset),
        .m0_addr_i      (m0_addr),
        .m0_data_i      (m0_wdata),
        .m0_rd_i        (m0_rd),
        .m0_wr_i        (m0_wr),
        .m0_data_o      (m0_data_o),
        .m0_done_o      (m0_done_o),
        .m0_err_o       (m0_err_o),
        .m1_addr_i      (m1_addr),
        .m1_data_i      (m1_wdata),
        .m1_rd_i        (m1_rd),
        .m1_wr_i        (m1_wr),
        .m1_data_o      (m1_data_o),
        .m1_done_o      (m1_done_o),
        .m1_err_o       (m1_err_o),
        .sub_VMEAddr_o  (sub_addr),
        .sub_VMEWrData_o(sub_wdata),
        .sub_VMERdData_i(sub_rdata),
        .sub_VMERdMem_o (sub_rd_mem),
        .sub_VMEWrMem_o (sub_wr_mem),
        .sub_VMERdDone_i(sub_rd_done),
        .sub_VMEWrDone_i(sub_wr_done),
        .grant_o        (grant_o)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int            m;
        bit            wr;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
        logic [31:0]   d0;
        logic [31:0]   d1;
        bit            err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] md0 = 32'd0;
    logic [31:0] md1 = 32'd0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          done_cnt = 0;
    int          wr_strb0 = 0;
    int          wr_strb1 = 0;
    int          slave_lat = 1;
    bit          slave_mute = 1'b0;
    bit          slave_spurious = 1'b0;
    bit          slv_wr;
    logic [AW-1:0] slv_addr;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    endtask

    function automatic logic [31:0] slave_val(input logic [AW-1:0] a);
        if (a == 14'h010) return 32'hCAFEF00D;
        return 32'h5EED0000 | {18'b0, a};
    endfunction

    // Queue the expected completion in service order and update the model of
    // both masters' read-data registers.
    function automatic void expect_op(input int m, input bit wr, input logic [AW-1:0] a,
                                      input logic [31:0] d, input bit err);
        exp_t e;
        logic [31:0] v;
        v = err ? 32'hFFFFFFFF : slave_val(a);
        if (!wr) begin
            if (m == 1) md1 = v;
            else md0 = v;
        end
        e.m = m; e.wr = wr; e.addr = a; e.wd = d; e.err = err;
        e.d0 = md0; e.d1 = md1;
        sb.push_back(e);
    endfunction

    task automatic set_req(input int m, input bit rd, input bit wr, input logic [AW-1:0] a,
                           input logic [31:0] d);
        if (m == 1) begin
            m1_rd = rd; m1_wr = wr; m1_addr = a; m1_wdata = d;
        end else begin
            m0_rd = rd; m0_wr = wr; m0_addr = a; m0_wdata = d;
        end
    endtask

    // Raise a request, wait (bounded) for done, drop it and leave a gap.
    // lat counts the cycles from the one where the request is first
    // sampled to the one where done_o shows.
    task automatic master_op(input int m, input bit wr, input bit both, input logic [AW-1:0] a,
                             input logic [31:0] d, output int lat);
        bit got;
        int n;
        set_req(m, !wr || both, wr, a, d);
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge aclk);
            n++;
            got = (m == 1) ? m1_done_o : m0_done_o;
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
        set_req(m, 1'b0, 1'b0, a, d);
        repeat (2) @(negedge aclk);
        lat = n;
    endtask

    // Bus slave model
    initial begin
        sub_rd_done = 1'b0;
        sub_wr_done = 1'b0;
        sub_rdata   = 32'h0;
        forever begin
            @(negedge aclk);
            if ((sub_rd_mem || sub_wr_mem) && !slave_mute) begin
                slv_wr   = sub_wr_mem;
                slv_addr = sub_addr;
                if (slave_spurious) begin
                    @(negedge aclk);
                    if (slv_wr) sub_rd_done = 1'b1;
                    else sub_wr_done = 1'b1;
                    sub_rdata = 32'hBAD0BAD0;
                    @(negedge aclk);
                    sub_rd_done = 1'b0;
                    sub_wr_done = 1'b0;
                    repeat (slave_lat - 2) @(negedge aclk);
                end else begin
                    repeat (slave_lat) @(negedge aclk);
                end
                if (slv_wr) begin
                    sub_wr_done = 1'b1;
                end else begin
                    sub_rd_done = 1'b1;
                    sub_rdata   = slave_val(slv_addr);
                end
                @(negedge aclk);
                sub_rd_done = 1'b0;
                sub_wr_done = 1'b0;
                sub_rdata   = 32'hDEADBEEF;
            end
        end
    end

    // Monitor: pops the scoreboard on done and peeks it on each strobe.
    initial begin
        exp_t e;
        bit   prev_strb;
        prev_strb = 1'b0;
        forever begin
            @(negedge aclk);
            if (m0_done_o || m1_done_o) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_done", {30'b0, m1_done_o, m0_done_o}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("done_owner", {30'b0, m1_done_o, m0_done_o}, (e.m == 1) ? 32'h2 : 32'h1);
                    check("err", {30'b0, m1_err_o, m0_err_o},
                          e.err ? ((e.m == 1) ? 32'h2 : 32'h1) : 32'h0);
                    check("m0_data", m0_data_o, e.d0);
                    check("m1_data", m1_data_o, e.d1);
                end
            end
            if (sub_rd_mem || sub_wr_mem) begin
                check("strobe_width", 32'(prev_strb), 32'h0);
                if (sub_wr_mem && grant_o == 2'b01) wr_strb0++;
                if (sub_wr_mem && grant_o == 2'b10) wr_strb1++;
                if (sb.size() == 0) begin
                    check("unexpected_strobe", {30'b0, sub_wr_mem, sub_rd_mem}, 32'h0);
                end else begin
                    e = sb[0];
                    check("strobe_dir", {30'b0, sub_wr_mem, sub_rd_mem}, e.wr ? 32'h2 : 32'h1);
                    check("bus_addr", 32'(sub_addr), 32'(e.addr));
                    if (e.wr) check("bus_wdata", sub_wdata, e.wd);
                    check("strobe_grant", 32'(grant_o), (e.m == 1) ? 32'h2 : 32'h1);
                end
            end
            prev_strb = sub_rd_mem | sub_wr_mem;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d checks, expected completion", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat0, lat1, d;
        bit bad;
        areset = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, 32'd0);
        set_req(1, 1'b0, 1'b0, '0, 32'd0);
        repeat (3) @(negedge aclk);
        areset = 1'b0;

        check("rst_grant", 32'(grant_o), 32'h0);
        check("rst_ctrl", {26'b0, sub_rd_mem, sub_wr_mem, m0_done_o, m1_done_o, m0_err_o, m1_err_o}, 32'h0);
        check("rst_m0_data", m0_data_o, 32'h0);
        check("rst_m1_data", m1_data_o, 32'h0);
        check("rst_addr", 32'(sub_addr), 32'h0);
        check("rst_wdata", sub_wdata, 32'h0);

        // m0 read, completion three cycles after the strobe
        slave_lat = 3;
        expect_op(0, 1'b0, 14'h010, 32'd0, 1'b0);
        master_op(0, 1'b0, 1'b0, 14'h010, 32'd0, lat);
        check("lat_read3", 32'(lat), 32'd5);
        check("grant_idle", 32'(grant_o), 32'h0);
        check("addr_hold", 32'(sub_addr), 32'h010);

        // minimum turnaround
        slave_lat = 0;
        expect_op(1, 1'b0, 14'h2A3, 32'd0, 1'b0);
        master_op(1, 1'b0, 1'b0, 14'h2A3, 32'd0, lat);
        check("lat_min", 32'(lat), 32'd2);

        // rd and wr together act as a write
        slave_lat = 1;
        expect_op(1, 1'b1, 14'h1FF, 32'h12345678, 1'b0);
        master_op(1, 1'b1, 1'b1, 14'h1FF, 32'h12345678, lat);
        check("lat_rdwr", 32'(lat), 32'd3);

        // simultaneous writes just after reset
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        md0 = 32'd0;
        md1 = 32'd0;
        wr_strb0 = 0;
        wr_strb1 = 0;
        expect_op(0, 1'b1, 14'h0AA, 32'hA0A0A0A0, 1'b0);
        expect_op(1, 1'b1, 14'h0BB, 32'hB0B0B0B0, 1'b0);
        fork
            master_op(0, 1'b1, 1'b0, 14'h0AA, 32'hA0A0A0A0, lat0);
            master_op(1, 1'b1, 1'b0, 14'h0BB, 32'hB0B0B0B0, lat1);
        join
        check("tie_lat_m0", 32'(lat0), 32'd3);
        check("tie_lat_m1", 32'(lat1), 32'd7);
        check("wr_strobes_m0", 32'(wr_strb0), 32'd1);
        check("wr_strobes_m1", 32'(wr_strb1), 32'd1);

        // continuous requests alternate 0,1,0,1,0,1
        slave_lat = 2;
        for (int i = 0; i < 3; i++) begin
            expect_op(0, 1'b0, 14'(14'h100 + i), 32'd0, 1'b0);
            expect_op(1, 1'b1, 14'(14'h200 + i), 32'hC0DE0000 + 32'(i), 1'b0);
        end
        fork
            begin
                for (int i = 0; i < 3; i++) master_op(0, 1'b0, 1'b0, 14'(14'h100 + i), 32'd0, lat0);
            end
            begin
                for (int j = 0; j < 3; j++) master_op(1, 1'b1, 1'b0, 14'(14'h200 + j), 32'hC0DE0000 + 32'(j), lat1);
            end
        join
        check("rr_drained", 32'(sb.size()), 32'd0);

        // wrong-direction completions are ignored
        slave_spurious = 1'b1;
        slave_lat = 4;
        expect_op(0, 1'b0, 14'h033, 32'd0, 1'b0);
        master_op(0, 1'b0, 1'b0, 14'h033, 32'd0, lat);
        check("lat_spurious_rd", 32'(lat), 32'd6);
        expect_op(1, 1'b1, 14'h044, 32'h44444444, 1'b0);
        master_op(1, 1'b1, 1'b0, 14'h044, 32'h44444444, lat);
        check("lat_spurious_wr", 32'(lat), 32'd6);
        slave_spurious = 1'b0;

`ifdef CERNBE_ARB_TIMEOUT_EN
        slave_mute = 1'b1;
        expect_op(1, 1'b0, 14'h077, 32'd0, 1'b1);
        master_op(1, 1'b0, 1'b0, 14'h077, 32'd0, lat);
        check("tmo_lat", 32'(lat), 32'd9);
        slave_mute = 1'b0;
        slave_lat = 7;
        expect_op(0, 1'b0, 14'h078, 32'd0, 1'b0);
        master_op(0, 1'b0, 1'b0, 14'h078, 32'd0, lat);
        check("tmo_edge_lat", 32'(lat), 32'd9);
`else
        slave_lat = 20;
        expect_op(0, 1'b0, 14'h079, 32'd0, 1'b0);
        master_op(0, 1'b0, 1'b0, 14'h079, 32'd0, lat);
        check("long_wait_lat", 32'(lat), 32'd22);
`endif

        // reset in WAIT, completion arrives two cycles later
        slave_lat = 3;
        expect_op(0, 1'b0, 14'h055, 32'd0, 1'b0);
        set_req(0, 1'b1, 1'b0, 14'h055, 32'd0);
        repeat (2) @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        set_req(0, 1'b0, 1'b0, 14'h055, 32'd0);
        sb.delete();
        md0 = 32'd0;
        md1 = 32'd0;
        d = done_cnt;
        bad = 1'b0;
        repeat (8) begin
            @(negedge aclk);
            if (grant_o != 2'b00 || sub_rd_mem || sub_wr_mem || m0_done_o || m1_done_o ||
                m0_err_o || m1_err_o || m0_data_o != 32'd0 || m1_data_o != 32'd0 ||
                sub_addr != '0 || sub_wdata != 32'd0) bad = 1'b1;
        end
        check("abort_quiet", 32'(bad), 32'h0);
        check("abort_no_done", 32'(done_cnt - d), 32'h0);

        // normal service after the abort
        slave_lat = 1;
        expect_op(1, 1'b0, 14'h3FF, 32'd0, 1'b0);
        master_op(1, 1'b0, 1'b0, 14'h3FF, 32'd0, lat);
        check("lat_recover", 32'(lat), 32'd3);
        check("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
